simple_mem_responder: RTL and testbench
=======================================

Name: simple_mem_responder

Overview:
- Target/responder end of the simplified memory interface (MemReq/MemResp).
- Stands in for a DRAM channel: accepts read/write requests from an initiator (role app or interleaver output), stores 512-bit lines in on-chip RAM, and returns read data in order.
- Used as a behavioural/BRAM channel model in simulation and as a small scratch memory on hardware.

Parameters:
- LOG_WORDS, 10, log2 number of 64-byte lines stored (default 64 KB).
- READ_LATENCY, 2, cycles from read grant to entry in the response queue (1..8).
- RESP_LOG_DEPTH, 4, log2 response queue depth.

Ports:
- clk  in  1  user clock.
- reset_n  in  1  asynchronous active-low reset.
- mem_req  in  MemReq (578)  {valid, isWrite, addr[63:0], data[511:0]}.
- mem_req_grant  out  1  request accepted this cycle.
- mem_resp  out  MemResp (513)  {valid, data[511:0]}.
- mem_resp_grant  in  1  initiator consumes mem_resp this cycle.
- rd_count  out  32  granted reads since reset.
- wr_count  out  32  granted writes since reset.

Behaviour:
- Reset (reset_n low, asynchronous): mem_req_grant=0, mem_resp.valid=0, mem_resp.data=0, rd_count=wr_count=0; read pipeline valids cleared; response queue emptied; credit counter = 2^RESP_LOG_DEPTH. RAM contents are not cleared.
- Addressing: line index = addr[LOG_WORDS+5:6]. addr[5:0] and bits above LOG_WORDS+5 are ignored (aliasing wraps).
- Request handshake: mem_req_grant is combinational from mem_req and internal state. It may depend on mem_req.valid, and it is 0 whenever valid=0. A request transfers on a cycle where valid and grant are both high.
- Writes: always granted. RAM is written at the clock edge. No response is generated. wr_count increments.
- Reads: granted only when credits > 0.
  - credits = queue depth minus (queue occupancy + reads in flight), tracked as one counter: decrement on read grant, increment on response dequeue. Simultaneous grant and dequeue leave it unchanged.
  - Granted read data enters the response queue exactly READ_LATENCY cycles after the grant edge.
  - rd_count increments on each granted read.
- Ordering: requests take effect strictly in grant order. A read granted the cycle after a write to the same line returns the new data. RAM is read-first relative to writes on the same edge, and only one request is granted per cycle, so no same-cycle conflict exists.
- Response handshake:
  - mem_resp.valid = response queue not empty; mem_resp.data = queue head.
  - Dequeue when valid && mem_resp_grant. mem_resp_grant while empty is ignored.
  - Data is held stable while valid and not granted.
- Back-pressure: the queue can never overflow, because credits cover in-flight reads. With a full queue and no grant, reads stall (grant=0) while writes continue.
- Counters wrap modulo 2^32.
- Reset mid-operation: in-flight reads and queued responses are discarded. The first request after reset_n deasserts can be granted on the first clock edge.

Decomposition:
- Package (ShellTypes): MemReq, MemResp already exist. Add MEM_LINE_BYTES=64 and MEM_LINE_SHIFT=6 constants.
- Response queue: the existing FIFO module, WIDTH=512, LOG_DEPTH=RESP_LOG_DEPTH.
- One natural sub-module, mem_read_pipe: a READ_LATENCY-stage valid/data shift register carrying RAM output to the FIFO write port.
- RAM array, credit counter and stat counters stay in the top.

Test Plan:
- Write/read back: write lines 0x0, 0x40, 0x80 with data 0xA0.., 0xA1.., 0xA2.., then read the same addresses with mem_resp_grant=1 → three responses in order with matching data, each appearing READ_LATENCY+1 cycles after its grant (FIFO registered). rd_count=3, wr_count=3.
- Credit back-pressure: mem_resp_grant=0, issue 20 consecutive reads with depth 16 → exactly 16 grants, then grant=0. Raise mem_resp_grant → one new grant per dequeue, and all 20 responses arrive in order.
- Writes during stall: queue full of reads, then issue a write to 0x100 → write granted immediately. A later read of 0x100 returns the new data.
- Aliasing and low bits: with LOG_WORDS=10, write addr 0x10000 data X, read addr 0x0 → X. Read addr 0x3F → X.
- Read-after-write back-to-back: write 0x200=Y at cycle n, read 0x200 at cycle n+1 → Y.
- Reset mid-stream: 8 reads outstanding, pulse reset_n low between edges → mem_resp.valid drops immediately, counters read 0, and after release 16 reads are grantable. RAM still holds the earlier data.

Source files
------------

// File: rtl/simple_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// simple_mem_responder_pkg
// Shared types for the simplified memory interface.
//   MemReq  : {valid, isWrite, addr[63:0], data[511:0]}  (578 bits)
//   MemResp : {valid, data[511:0]}                        (513 bits)
// ----------------------------------------------------------------------------
package simple_mem_responder_pkg;

   localparam int unsigned MEM_LINE_BYTES = 64;
   localparam int unsigned MEM_LINE_SHIFT = 6;
   localparam int unsigned MEM_LINE_BITS  = MEM_LINE_BYTES * 8;

   typedef struct packed {
      logic        valid;
      logic        isWrite;
      logic [63:0] addr;
      logic [MEM_LINE_BITS-1:0] data;
   } MemReq;

   typedef struct packed {
      logic        valid;
      logic [MEM_LINE_BITS-1:0] data;
   } MemResp;

endpackage

// File: rtl/simple_mem_responder_fifo.sv
// ----------------------------------------------------------------------------
// simple_mem_responder_fifo
// Synchronous FIFO with a combinational head. Writes when full and reads when
// empty are ignored.
//   clk, reset_n       : clock, asynchronous active-low reset (pointers only)
//   i_wr_en, i_wr_data : push port
//   i_rd_en            : pop the head
//   o_empty, o_full    : occupancy flags
//   o_rd_data          : current head
// ----------------------------------------------------------------------------
module simple_mem_responder_fifo #(
   parameter int unsigned WIDTH     = 512,
   parameter int unsigned LOG_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic             o_empty,
   output logic             o_full,
   output logic [WIDTH-1:0] o_rd_data
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] PTR_ONE = (LOG_DEPTH + 1)'(1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [LOG_DEPTH:0] r_wr_ptr;
   logic [LOG_DEPTH:0] r_rd_ptr;
   logic               w_push;
   logic               w_pop;

   // Extra pointer MSB distinguishes full from empty.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                    (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);
   assign w_push  = i_wr_en && !o_full;
   assign w_pop   = i_rd_en && !o_empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= i_wr_data;
   end

   assign o_rd_data = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];

endmodule

// File: rtl/simple_mem_responder_read_pipe.sv
// ----------------------------------------------------------------------------
// simple_mem_responder_read_pipe
// LATENCY-stage valid/data shift register carrying RAM read data toward the
// response queue. Stage 0 captures on the grant edge, so o_valid rises
// LATENCY-1 edges later and the consumer writes it on the following edge.
//   clk, reset_n     : clock, asynchronous active-low reset (valids only)
//   i_valid, i_data  : read grant and RAM data sampled at the grant edge
//   o_valid, o_data  : last stage
// ----------------------------------------------------------------------------
module simple_mem_responder_read_pipe #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned WIDTH   = 512
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [LATENCY-1:0] r_valid;
   logic [WIDTH-1:0]   r_data [LATENCY];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         for (int i = 1; i < LATENCY; i++) r_valid[i] <= r_valid[i-1];
      end
   end

   // Data needs no reset; it is qualified by r_valid.
   always_ff @(posedge clk) begin
      r_data[0] <= i_data;
      for (int i = 1; i < LATENCY; i++) r_data[i] <= r_data[i-1];
   end

   assign o_valid = r_valid[LATENCY-1];
   assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/simple_mem_responder.sv
// ----------------------------------------------------------------------------
// simple_mem_responder
// Responder end of the MemReq/MemResp interface: an on-chip line store that
// accepts one request per cycle and returns read data in grant order.
//   clk, reset_n    : clock, asynchronous active-low reset
//   mem_req         : MemReq {valid, isWrite, addr, data}
//   mem_req_grant   : request accepted this cycle (combinational)
//   mem_resp        : MemResp {valid, data}, head of the response queue
//   mem_resp_grant  : initiator consumes mem_resp this cycle
//   rd_count        : granted reads since reset (wraps)
//   wr_count        : granted writes since reset (wraps)
// ----------------------------------------------------------------------------
module simple_mem_responder
   import simple_mem_responder_pkg::*;
#(
   parameter int unsigned LOG_WORDS      = 10,
   parameter int unsigned READ_LATENCY   = 2,
   parameter int unsigned RESP_LOG_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [$bits(MemReq)-1:0]   mem_req,
   output logic                       mem_req_grant,
   output logic [$bits(MemResp)-1:0]  mem_resp,
   input  logic                       mem_resp_grant,
   output logic [31:0]                rd_count,
   output logic [31:0]                wr_count
);

   localparam int unsigned WORDS      = 1 << LOG_WORDS;
   localparam int unsigned RESP_DEPTH = 1 << RESP_LOG_DEPTH;
   localparam logic [RESP_LOG_DEPTH:0] CREDITS_MAX = (RESP_LOG_DEPTH + 1)'(RESP_DEPTH);
   localparam logic [RESP_LOG_DEPTH:0] CREDIT_ONE  = (RESP_LOG_DEPTH + 1)'(1);

   MemReq                         w_req;
   MemResp                        w_resp;
   logic [LOG_WORDS-1:0]          w_idx;
   logic                          w_unused_addr;
   logic                          w_req_live;
   logic                          w_wr_grant;
   logic                          w_rd_grant;
   logic                          w_deq;
   logic [MEM_LINE_BITS-1:0]      w_ram_rd_data;
   logic                          w_pipe_valid;
   logic [MEM_LINE_BITS-1:0]      w_pipe_data;
   logic                          w_fifo_empty;
   logic                          w_fifo_full;
   logic [MEM_LINE_BITS-1:0]      w_fifo_head;

   logic [MEM_LINE_BITS-1:0]      r_ram [WORDS];
   logic [RESP_LOG_DEPTH:0]       r_credits;
   logic [31:0]                   r_rd_count;
   logic [31:0]                   r_wr_count;

   assign w_req = mem_req;

   // Line index; offset bits and address bits above the store alias away.
   assign w_idx = w_req.addr[LOG_WORDS+MEM_LINE_SHIFT-1:MEM_LINE_SHIFT];
   assign w_unused_addr = ^{w_req.addr[63:LOG_WORDS+MEM_LINE_SHIFT],
                            w_req.addr[MEM_LINE_SHIFT-1:0]};

   // Grant is forced low while reset is asserted.
   assign w_req_live    = w_req.valid && reset_n;
   assign w_wr_grant    = w_req_live && w_req.isWrite;
   assign w_rd_grant    = w_req_live && !w_req.isWrite && (r_credits != '0);
   assign mem_req_grant = w_wr_grant || w_rd_grant;

   // Combinational read sampled by the pipe on the grant edge gives read-first
   // behaviour against a write on that same edge.
   always_ff @(posedge clk) begin
      if (w_wr_grant) r_ram[w_idx] <= w_req.data;
   end
   assign w_ram_rd_data = r_ram[w_idx];

   simple_mem_responder_read_pipe #(
      .LATENCY (READ_LATENCY),
      .WIDTH   (MEM_LINE_BITS)
   ) u_read_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (w_rd_grant),
      .i_data  (w_ram_rd_data),
      .o_valid (w_pipe_valid),
      .o_data  (w_pipe_data)
   );

   simple_mem_responder_fifo #(
      .WIDTH     (MEM_LINE_BITS),
      .LOG_DEPTH (RESP_LOG_DEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_en   (w_pipe_valid),
      .i_wr_data (w_pipe_data),
      .i_rd_en   (mem_resp_grant),
      .o_empty   (w_fifo_empty),
      .o_full    (w_fifo_full),
      .o_rd_data (w_fifo_head)
   );

   assign w_deq = !w_fifo_empty && mem_resp_grant;

   // Credits cover both queued responses and reads still in the pipe, so the
   // queue cannot be full when the pipe delivers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_credits <= CREDITS_MAX;
      end else begin
         case ({w_rd_grant, w_deq})
            2'b10:   r_credits <= r_credits - CREDIT_ONE;
            2'b01:   r_credits <= r_credits + CREDIT_ONE;
            default: r_credits <= r_credits;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_rd_grant) r_rd_count <= r_rd_count + 32'd1;
         if (w_wr_grant) r_wr_count <= r_wr_count + 32'd1;
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;

   always_comb begin
      w_resp       = '0;
      w_resp.valid = !w_fifo_empty;
      w_resp.data  = w_fifo_empty ? '0 : w_fifo_head;
   end
   assign mem_resp = w_resp;

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(w_pipe_valid && w_fifo_full));

endmodule

// File: tb/tb_simple_mem_responder.sv
// Bench for simple_mem_responder (defaults: 1024 lines, read latency 2, queue depth 16).
// A negedge model predicts grant, response and counters from queue/array bookkeeping;
// directed tasks add literal expectations.
module tb_simple_mem_responder;

   localparam int LAT   = 2;
   localparam int DEPTH = 16;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req_valid;
   logic         req_wr;
   logic [63:0]  req_addr;
   logic [511:0] req_data;
   logic [577:0] mem_req;
   logic         mem_req_grant;
   logic [512:0] mem_resp;
   logic         mem_resp_grant;
   logic [31:0]  rd_count;
   logic [31:0]  wr_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign mem_req = {req_valid, req_wr, req_addr, req_data};

   simple_mem_responder dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mem_req        (mem_req),
      .mem_req_grant  (mem_req_grant),
      .mem_resp       (mem_resp),
      .mem_resp_grant (mem_resp_grant),
      .rd_count       (rd_count),
      .wr_count       (wr_count)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [511:0] data;
      int           vis;
   } pend_t;

   logic [511:0] m_mem [1024];
   logic [511:0] m_respq [$];
   pend_t        m_pend [$];
   int           m_cyc = 0;
   logic [31:0]  m_rd  = '0;
   logic [31:0]  m_wr  = '0;

   task automatic model_reset();
      m_respq.delete();
      m_pend.delete();
      m_rd = '0;
      m_wr = '0;
   endtask

   always @(negedge clk) begin
      logic  exp_valid;
      logic  exp_grant;
      int    idx;
      pend_t p;
      if (!reset_n) begin
         chk("reset_grant", {511'd0, mem_req_grant}, 512'd0);
         chk("reset_resp_valid", {511'd0, mem_resp[512]}, 512'd0);
         chk("reset_resp_data", mem_resp[511:0], 512'd0);
         chk("reset_rd_count", {480'd0, rd_count}, 512'd0);
         chk("reset_wr_count", {480'd0, wr_count}, 512'd0);
      end else begin
         exp_valid = (m_respq.size() != 0);
         exp_grant = req_valid && (req_wr || (m_respq.size() + m_pend.size()) < DEPTH);
         chk("resp_valid", {511'd0, mem_resp[512]}, {511'd0, exp_valid});
         if (exp_valid) chk("resp_data", mem_resp[511:0], m_respq[0]);
         chk("req_grant", {511'd0, mem_req_grant}, {511'd0, exp_grant});
         chk("rd_count", {480'd0, rd_count}, {480'd0, m_rd});
         chk("wr_count", {480'd0, wr_count}, {480'd0, m_wr});
         idx = int'(req_addr[15:6]);
         if (exp_grant && req_wr) begin
            m_mem[idx] = req_data;
            m_wr++;
         end
         if (exp_grant && !req_wr) begin
            p.data = m_mem[idx];
            p.vis  = m_cyc + LAT + 1;
            m_pend.push_back(p);
            m_rd++;
         end
         if (exp_valid && mem_resp_grant) void'(m_respq.pop_front());
         m_cyc++;
         while (m_pend.size() != 0 && m_pend[0].vis <= m_cyc) begin
            p = m_pend.pop_front();
            m_respq.push_back(p.data);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic wr, input logic [63:0] a, input logic [511:0] d);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_data  = d;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_wr    = 1'b0;
   endtask

   task automatic step(output logic g);
      @(negedge clk);
      g = mem_req_grant;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [63:0] a, input logic [511:0] d);
      logic g;
      int   n;
      n = 0;
      drive(wr, a, d);
      do begin
         step(g);
         n++;
      end while (!g && n < 200);
      if (!g) chk("issue_timeout", {511'd0, g}, 512'd1);
      idle();
   endtask

   task automatic wait_resp(output logic [511:0] d, output int lat);
      logic done;
      done = 1'b0;
      d    = '0;
      lat  = 1;
      while (!done) begin
         @(negedge clk);
         if (mem_resp[512]) begin
            d    = mem_resp[511:0];
            done = 1'b1;
         end else if (lat >= 50) begin
            chk("resp_timeout", {511'd0, mem_resp[512]}, 512'd1);
            done = 1'b1;
         end else begin
            lat++;
            @(posedge clk);
            #1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      @(negedge clk);
      while (mem_resp[512] && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (mem_resp[512]) chk("drain_timeout", {511'd0, mem_resp[512]}, 512'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic read_capture(input logic [63:0] a, output logic [511:0] d, output int lat);
      wait_empty();
      issue(1'b0, a, '0);
      wait_resp(d, lat);
   endtask

   function automatic logic [511:0] cpat(input int i);
      return {16{32'hC000_0000 + 32'(i)}};
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      logic         g;
      logic [511:0] d;
      logic [511:0] x;
      logic [511:0] y;
      logic [511:0] z;
      int           lat;
      int           k;
      int           n;

      reset_n        = 1'b0;
      req_valid      = 1'b0;
      req_wr         = 1'b0;
      req_addr       = '0;
      req_data       = '0;
      mem_resp_grant = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // Write/read back, three in order.
      mem_resp_grant = 1'b1;
      issue(1'b1, 64'h0,  {64{8'hA0}});
      issue(1'b1, 64'h40, {64{8'hA1}});
      issue(1'b1, 64'h80, {64{8'hA2}});
      issue(1'b0, 64'h0,  '0);
      issue(1'b0, 64'h40, '0);
      issue(1'b0, 64'h80, '0);
      wait_resp(d, lat);
      chk("t1_data0", d, {64{8'hA0}});
      chk("t1_lat0", 512'(lat), 512'd1);
      wait_resp(d, lat);
      chk("t1_data1", d, {64{8'hA1}});
      chk("t1_lat1", 512'(lat), 512'd1);
      wait_resp(d, lat);
      chk("t1_data2", d, {64{8'hA2}});
      chk("t1_rd_count", {480'd0, rd_count}, 512'd3);
      chk("t1_wr_count", {480'd0, wr_count}, 512'd3);

      // Credit back-pressure with writes during the stall.
      for (int i = 0; i < 20; i++) issue(1'b1, 64'(i * 64), cpat(i));
      mem_resp_grant = 1'b0;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 64'(k * 64), '0);
         step(g);
         if (g) k++;
      end
      idle();
      chk("t2_stalled_grants", 512'(k), 512'd16);
      z = {8{64'hDEAD_BEEF_0000_0100}};
      drive(1'b1, 64'h100, z);
      step(g);
      idle();
      chk("t2_write_in_stall", {511'd0, g}, 512'd1);
      mem_resp_grant = 1'b1;
      n = 0;
      while (k < 20 && n < 100) begin
         drive(1'b0, 64'(k * 64), '0);
         step(g);
         if (g) k++;
         n++;
      end
      idle();
      chk("t2_all_grants", 512'(k), 512'd20);
      read_capture(64'h100, d, lat);
      chk("t2_read_new_0x100", d, z);
      chk("t2_read_latency", 512'(lat), 512'(LAT + 1));

      // Aliasing and ignored offset bits.
      x = {8{64'h0123_4567_89AB_CDEF}};
      issue(1'b1, 64'h10000, x);
      read_capture(64'h0, d, lat);
      chk("t3_alias_0x0", d, x);
      read_capture(64'h3F, d, lat);
      chk("t3_alias_0x3f", d, x);

      // Read immediately after write to the same line.
      y = {16{32'h5A5A_0200}};
      wait_empty();
      issue(1'b1, 64'h200, y);
      issue(1'b0, 64'h200, '0);
      wait_resp(d, lat);
      chk("t4_raw", d, y);

      // Reset mid-stream.
      wait_empty();
      mem_resp_grant = 1'b0;
      for (int i = 0; i < 8; i++) issue(1'b0, 64'((i + 8) * 64), '0);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_valid_drop", {511'd0, mem_resp[512]}, 512'd0);
      chk("t5_rd_count", {480'd0, rd_count}, 512'd0);
      chk("t5_wr_count", {480'd0, wr_count}, 512'd0);
      #1 reset_n = 1'b1;
      model_reset();
      k = 0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b0, 64'((8 + k % 8) * 64), '0);
         step(g);
         if (g) k++;
      end
      idle();
      chk("t5_grants_after_reset", 512'(k), 512'd16);
      chk("t5_17th_stalled", {511'd0, g}, 512'd0);
      mem_resp_grant = 1'b1;
      read_capture(64'h40, d, lat);
      chk("t5_ram_kept", d, cpat(1));

      wait_empty();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
